// File: rtl/seq_detect_ctrl_if.sv
// Stream handshake bundle for seq_detect_ctrl.
// The host drives words (master); the controller accepts them (slave).
// A word transfers on a clock edge where in_valid and in_ready are both high.
interface seq_detect_ctrl_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: sequences an external serial 1011 detector.
// Parallel words are shifted MSB-first onto o_det_bit, one bit per clock.
// The detector is held in reset on every cycle where no bit is driven, so a
// pattern can never straddle an underrun gap. Hits are counted per stream.
// Optional build macro SEQ_DETECT_CTRL_SAT_EN: when defined, the match
// counter saturates at all-ones. When undefined, it wraps.
module seq_detect_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    seq_detect_ctrl_if.slave s_in,
    output logic             o_det_reset,
    output logic             o_det_bit,
    input  logic             i_det_seen,
    output logic [CNT_W-1:0] o_match_count,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_gap_err
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_last_q;
    logic [CNT_W-1:0]  r_match_count;
    logic              r_gap_err;

    logic w_final_bit;
    logic w_in_ready;
    logic w_accept;

    // Advance the hit counter by one; saturating or wrapping by build option.
    function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] cnt);
`ifdef SEQ_DETECT_CTRL_SAT_EN
        if (cnt == {CNT_W{1'b1}}) begin
            count_inc = cnt;
        end else begin
            count_inc = cnt + CNT_W'(1);
        end
`else
        count_inc = cnt + CNT_W'(1);
`endif
    endfunction

    // Ready decode: open in IDLE/WAIT, and on the last bit of a non-final word.
    always_comb begin
        w_final_bit = (r_bit_idx == LAST_IDX);
        w_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE:  w_in_ready = 1'b1;
            ST_SHIFT: w_in_ready = w_final_bit & ~r_last_q;
            ST_WAIT:  w_in_ready = 1'b1;
            ST_DONE:  w_in_ready = 1'b0;
            default:  w_in_ready = 1'b0;
        endcase
        w_accept = s_in.in_valid & w_in_ready;
    end

    assign s_in.in_ready = w_in_ready;

    // The detector only runs while a bit is actually on its input.
    assign o_det_reset   = reset | (r_state != ST_SHIFT);
    assign o_det_bit     = (r_state == ST_SHIFT) ? r_shreg[DATA_W-1] : 1'b0;
    assign o_match_count = r_match_count;
    assign o_done        = (r_state == ST_DONE);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_gap_err     = r_gap_err;

    // Controller FSM: word load, serialization, hit counting and underrun tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_shreg       <= {DATA_W{1'b0}};
            r_bit_idx     <= IDX_ZERO;
            r_last_q      <= 1'b0;
            r_match_count <= {CNT_W{1'b0}};
            r_gap_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg       <= s_in.in_data;
                        r_last_q      <= s_in.in_last;
                        r_bit_idx     <= IDX_ZERO;
                        r_match_count <= {CNT_W{1'b0}};
                        r_gap_err     <= 1'b0;
                        r_state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (i_det_seen) begin
                        r_match_count <= count_inc(r_match_count);
                    end
                    r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
                    r_bit_idx <= r_bit_idx + IDX_ONE;
                    if (w_final_bit) begin
                        r_bit_idx <= IDX_ZERO;
                        if (r_last_q) begin
                            r_state <= ST_DONE;
                        end else if (w_accept) begin
                            // Back-to-back reload keeps the bit stream gap-free.
                            r_shreg  <= s_in.in_data;
                            r_last_q <= s_in.in_last;
                        end else begin
                            r_gap_err <= 1'b1;
                            r_state   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // The count survives the underrun; only the detector is cleared.
                    if (w_accept) begin
                        r_shreg   <= s_in.in_data;
                        r_last_q  <= s_in.in_last;
                        r_bit_idx <= IDX_ZERO;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
